// File: rtl/coredma_dsc_cache_pkg.sv
// Shared constants and types for the DMA descriptor cache controller.
// DSC_DATA_W     : descriptor width in bits
// DSC_DEPTH      : entries in the descriptor cache micro-RAM
// DSC_ADDR_W     : RAM address width, log2(DSC_DEPTH)
// DSC_OBUF_DEPTH : output buffer entries; matches the read loop length so
//                  one descriptor per cycle can be sustained
package coredma_dsc_cache_pkg;

  localparam int DSC_DATA_W     = 88;
  localparam int DSC_DEPTH      = 4;
  localparam int DSC_ADDR_W     = 2;
  localparam int DSC_OBUF_DEPTH = 3;

  typedef logic [DSC_DATA_W-1:0] dsc_t;

endpackage

// File: rtl/coredma_dsc_cache_obuf.sv
// Output buffer for the descriptor cache: a small synchronous FIFO that
// absorbs descriptors arriving from the RAM read pipeline.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (control only)
//   clear        : synchronous discard of all entries
//   push         : push_data is written at the end of this cycle
//   push_data    : descriptor from the RAM read-data register
//   pop          : consumer takes head_data this cycle (ignored when empty)
//   head_data    : oldest entry, zero while empty
//   count        : number of stored entries
//   not_empty    : head_data is valid
// The read scheduler guarantees a free slot for every push; a push into a
// full buffer without a simultaneous pop is flagged by an assertion.
module coredma_dsc_cache_obuf
  import coredma_dsc_cache_pkg::*;
#(
  parameter int DATA_W = DSC_DATA_W,
  parameter int DEPTH  = DSC_OBUF_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              not_empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && not_empty && !clear;
  assign do_push   = push && !clear && (!full || do_pop);

  // Masked so the output reads zero whenever nothing is buffered.
  assign head_data = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  obuf_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n || clear)
    !(push && full && !do_pop)
  );

endmodule

// File: rtl/coredma_dsc_cache_ctrl.sv
// Queue controller for the descriptor cache micro-RAM.
// Descriptors from the fetch engine are written into the RAM in FIFO order.
// Reads are issued only while an output-buffer slot is guaranteed for the
// result (credit scheme), the two-cycle registered RAM read latency is
// tracked by a valid shift register, and results land in a small output
// buffer that drives the channel-engine handshake. The RAM macro wrapper
// ties the RAM SRST_N inputs high and the AD_N inputs to VCC.
// Ports:
//   CLK, RESETN      : clock shared with the RAM, async active-low reset
//   flush            : synchronous discard of queued and in-flight entries
//   wr_valid/ready   : descriptor write handshake, wr_data payload
//   rd_valid/ready   : descriptor read handshake, rd_data payload
//   level            : RAM slots occupied
//   ram_blk_en       : RAM block enable, high once out of reset
//   ram_w_en/addr/data        : RAM write port
//   ram_r_addr/addr_en        : RAM read-address register
//   ram_r_data_en/ram_r_data  : RAM read-data register
module coredma_dsc_cache_ctrl
  import coredma_dsc_cache_pkg::*;
#(
  parameter int DATA_W     = DSC_DATA_W,
  parameter int DEPTH      = DSC_DEPTH,
  parameter int ADDR_W     = DSC_ADDR_W,
  parameter int OBUF_DEPTH = DSC_OBUF_DEPTH
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              ram_blk_en,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic              ram_r_addr_en,
  output logic              ram_r_data_en,
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam int LVL_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  logic              blk_en_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [LVL_W-1:0]  unread;
  logic [LVL_W-1:0]  level_q;
  logic              vld_p1;
  logic              vld_p2;
  logic [CNT_W-1:0]  obuf_count;
  logic              wr_fire;
  logic              rd_issue;
  logic              pop;
  logic [CRD_W-1:0]  credits_used;

  // blk_en_q is low only while in reset, which keeps wr_ready low there.
  assign wr_ready = blk_en_q && !flush && (level_q < LVL_W'(DEPTH));
  assign wr_fire  = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  // Every issued read owns an output-buffer slot from issue until it is
  // popped; a pop this cycle returns its credit immediately.
  assign credits_used = CRD_W'(obuf_count) + CRD_W'(vld_p1) + CRD_W'(vld_p2)
                        - CRD_W'(pop);

  // unread is registered, so a slot written this cycle is never read in the
  // same cycle.
  assign rd_issue = (unread != '0) && (credits_used < CRD_W'(OBUF_DEPTH)) && !flush;

  assign ram_blk_en    = blk_en_q;
  assign ram_w_en      = wr_fire;
  assign ram_w_addr    = wptr;
  assign ram_w_data    = wr_data;
  assign ram_r_addr    = rptr;
  assign ram_r_addr_en = rd_issue;
  assign ram_r_data_en = vld_p1;
  assign level         = level_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      blk_en_q <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      unread   <= '0;
      level_q  <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
    end else begin
      blk_en_q <= 1'b1;
      if (flush) begin
        wptr    <= '0;
        rptr    <= '0;
        unread  <= '0;
        level_q <= '0;
        vld_p1  <= 1'b0;
        vld_p2  <= 1'b0;
      end else begin
        // p0 -> p1: address registered in the RAM, array read next cycle
        vld_p1 <= rd_issue;
        // p1 -> p2: RAM read-data register loaded, data valid for the obuf
        vld_p2 <= vld_p1;
        if (wr_fire)  wptr <= wptr + ADDR_W'(1);
        if (rd_issue) rptr <= rptr + ADDR_W'(1);
        unread  <= unread + LVL_W'(wr_fire) - LVL_W'(rd_issue);
        // The slot is released once its array read has completed (stage 1),
        // so a rewrite can never race the pending read.
        level_q <= level_q + LVL_W'(wr_fire) - LVL_W'(vld_p1);
      end
    end
  end

  // p2 -> obuf: descriptor captured at the end of its data-valid cycle
  coredma_dsc_cache_obuf #(
    .DATA_W (DATA_W),
    .DEPTH  (OBUF_DEPTH)
  ) u_obuf (
    .clk       (CLK),
    .rst_n     (RESETN),
    .clear     (flush),
    .push      (vld_p2),
    .push_data (ram_r_data),
    .pop       (rd_ready),
    .head_data (rd_data),
    .count     (obuf_count),
    .not_empty (rd_valid)
  );

endmodule

// File: tb/tb_coredma_dsc_cache_ctrl.sv
module tb_coredma_dsc_cache_ctrl;
  import coredma_dsc_cache_pkg::*;

  localparam int DW = 88;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;
  logic          ram_blk_en;
  logic          ram_w_en;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic [AW-1:0] ram_r_addr;
  logic          ram_r_addr_en;
  logic          ram_r_data_en;
  logic [DW-1:0] ram_r_data;

  coredma_dsc_cache_ctrl dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .flush         (flush),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .level         (level),
    .ram_blk_en    (ram_blk_en),
    .ram_w_en      (ram_w_en),
    .ram_w_addr    (ram_w_addr),
    .ram_w_data    (ram_w_data),
    .ram_r_addr    (ram_r_addr),
    .ram_r_addr_en (ram_r_addr_en),
    .ram_r_data_en (ram_r_data_en),
    .ram_r_data    (ram_r_data)
  );

  always #5 CLK = ~CLK;

  // Behavioural model of the RAM: registered read address and read data.
  logic [DW-1:0] ram_mem [4];
  logic [AW-1:0] ram_ra = '0;
  logic [DW-1:0] ram_q = '0;
  always @(posedge CLK) begin
    if (ram_blk_en && ram_w_en)      ram_mem[ram_w_addr] <= ram_w_data;
    if (ram_blk_en && ram_r_addr_en) ram_ra <= ram_r_addr;
    if (ram_blk_en && ram_r_data_en) ram_q <= ram_mem[ram_ra];
  end
  assign ram_r_data = ram_q;

  int   vecs = 0;
  int   errs = 0;
  dsc_t exp_q[$];
  dsc_t exp_d;

  function automatic dsc_t pat(input int i);
    return {24'(i), 64'h0123_4567_89AB_CDEF ^ {2{32'(i) * 32'h1111_1111}}};
  endfunction

  // Move to the drive point: 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    RESETN = 1'b0;
    #3;
    vecs++;
    if ({wr_ready, rd_valid, ram_blk_en, ram_w_en, ram_r_addr_en, ram_r_data_en} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {wr_ready, rd_valid, ram_blk_en, ram_w_en, ram_r_addr_en, ram_r_data_en});
    end
    vecs++;
    if ({level, ram_w_addr, ram_r_addr} !== 7'b0 || rd_data !== '0) begin
      errs++;
      $display("FAIL reset_regs level=%0d w_addr=%0d r_addr=%0d rd_data=%h want all 0",
               level, ram_w_addr, ram_r_addr, rd_data);
    end
    cyc();
    cyc();
    RESETN = 1'b1;
    #3;
    vecs++;
    if (ram_blk_en !== 1'b0 || wr_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_release_early blk_en=%b wr_ready=%b want 0 0", ram_blk_en, wr_ready);
    end
    cyc();
    #3;
    vecs++;
    if (ram_blk_en !== 1'b1 || wr_ready !== 1'b1 || level !== 3'd0) begin
      errs++;
      $display("FAIL reset_after blk_en=%b wr_ready=%b level=%0d want 1 1 0",
               ram_blk_en, wr_ready, level);
    end
    cyc();
  endtask

  // One descriptor through an idle pipeline; expected per-cycle control
  // pattern {ram_w_en, ram_r_addr_en, ram_r_data_en, rd_valid, level}.
  task automatic test_single_write(input dsc_t d, input logic [AW-1:0] slot, input string nm);
    logic [6:0] exp_tab [6];
    exp_tab = '{7'b1000_000, 7'b0100_001, 7'b0010_001, 7'b0000_000, 7'b0001_000, 7'b0000_000};
    rd_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      wr_valid = (c == 0);
      wr_data  = d;
      #3;
      vecs++;
      if ({ram_w_en, ram_r_addr_en, ram_r_data_en, rd_valid, level} !== exp_tab[c]) begin
        errs++;
        $display("FAIL %s_ctrl c=%0d got=%b want=%b", nm, c,
                 {ram_w_en, ram_r_addr_en, ram_r_data_en, rd_valid, level}, exp_tab[c]);
      end
      if (c == 0) begin
        vecs++;
        if (ram_w_addr !== slot) begin
          errs++;
          $display("FAIL %s_w_addr got=%0d want=%0d", nm, ram_w_addr, slot);
        end
      end
      if (c == 1) begin
        vecs++;
        if (ram_r_addr !== slot) begin
          errs++;
          $display("FAIL %s_r_addr got=%0d want=%0d", nm, ram_r_addr, slot);
        end
      end
      if (c == 4) begin
        vecs++;
        if (rd_data !== d) begin
          errs++;
          $display("FAIL %s_data got=%h want=%h", nm, rd_data, d);
        end
      end
      cyc();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic test_fill();
    int idx;
    int pops;
    idx = 0;
    pops = 0;
    rd_ready = 1'b0;
    // Reads issue at c1..c3 and free slots at c2..c4, so 7 writes fit.
    for (int c = 0; c < 8; c++) begin
      wr_valid = 1'b1;
      wr_data  = pat(idx);
      #3;
      vecs++;
      if (wr_ready !== (c < 7) || rd_valid !== (c >= 4)) begin
        errs++;
        $display("FAIL fill_hs c=%0d wr_ready=%b rd_valid=%b want %b %b",
                 c, wr_ready, rd_valid, c < 7, c >= 4);
      end
      if (c == 7) begin
        vecs++;
        if (level !== 3'd4) begin
          errs++;
          $display("FAIL fill_level got=%0d want=4", level);
        end
      end
      if (wr_valid && wr_ready) begin
        exp_q.push_back(pat(idx));
        idx++;
      end
      cyc();
    end
    rd_ready = 1'b1;
    for (int c = 0; c < 40 && !(idx == 8 && exp_q.size() == 0); c++) begin
      wr_valid = (idx < 8);
      wr_data  = pat(idx);
      #3;
      if (wr_valid && wr_ready) begin
        exp_q.push_back(pat(idx));
        idx++;
      end
      if (rd_valid && rd_ready) begin
        pops++;
        vecs++;
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (rd_data !== exp_d) begin
          errs++;
          $display("FAIL fill_data pop=%0d got=%h want=%h", pops, rd_data, exp_d);
        end
      end
      cyc();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    vecs++;
    if (pops !== 8 || idx !== 8) begin
      errs++;
      $display("FAIL fill_drain pops=%0d written=%0d want 8 8", pops, idx);
    end
  endtask

  task automatic test_stream();
    int idx;
    int pops;
    int first_pop;
    int last_pop;
    idx = 0;
    pops = 0;
    first_pop = -1;
    last_pop = -1;
    rd_ready = 1'b1;
    for (int c = 0; c < 60 && pops < 20; c++) begin
      wr_valid = (idx < 20);
      wr_data  = pat(1000 + idx);
      #3;
      if (wr_valid) begin
        vecs++;
        if (wr_ready !== 1'b1) begin
          errs++;
          $display("FAIL stream_wr_ready c=%0d got=%b want=1", c, wr_ready);
        end
      end
      if (wr_valid && wr_ready) begin
        exp_q.push_back(pat(1000 + idx));
        idx++;
      end
      if (rd_valid && rd_ready) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
        vecs++;
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (rd_data !== exp_d) begin
          errs++;
          $display("FAIL stream_data pop=%0d got=%h want=%h", pops, rd_data, exp_d);
        end
      end
      cyc();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    vecs++;
    if (pops !== 20 || first_pop !== 4 || last_pop - first_pop !== 19) begin
      errs++;
      $display("FAIL stream_rate pops=%0d first=%0d span=%0d want 20 4 19",
               pops, first_pop, last_pop - first_pop);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int pops;
    int issued;
    idx = 0;
    pops = 0;
    issued = 0;
    for (int c = 0; c < 400 && pops < 30; c++) begin
      wr_valid = (idx < 30) && ($urandom_range(0, 3) != 0);
      wr_data  = pat(2000 + idx);
      rd_ready = 1'($urandom_range(0, 1));
      #3;
      if (ram_r_addr_en) issued++;
      if (wr_valid && wr_ready) begin
        exp_q.push_back(pat(2000 + idx));
        idx++;
      end
      if (rd_valid && rd_ready) begin
        pops++;
        vecs++;
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (rd_data !== exp_d) begin
          errs++;
          $display("FAIL bp_data pop=%0d got=%h want=%h", pops, rd_data, exp_d);
        end
      end
      vecs++;
      if (issued - pops > 3) begin
        errs++;
        $display("FAIL bp_credits c=%0d outstanding=%0d want<=3", c, issued - pops);
      end
      cyc();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    vecs++;
    if (pops !== 30 || issued !== 30 || exp_q.size() !== 0) begin
      errs++;
      $display("FAIL bp_count pops=%0d issued=%0d left=%0d want 30 30 0",
               pops, issued, exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic [1:0] exp_tab [6];
    dsc_t dn;
    dn = pat(777);
    // {rd_valid, ram_r_addr_en} for the six cycles after the flush.
    exp_tab = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    rd_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wr_valid = 1'b1;
      wr_data  = pat(300 + c);
      cyc();
    end
    // Flush cycle: one entry in the obuf, two reads in flight, writer active.
    flush    = 1'b1;
    wr_data  = pat(399);
    rd_ready = 1'b1;
    #3;
    vecs++;
    if ({wr_ready, ram_w_en, ram_r_addr_en, rd_valid} !== 4'b0001) begin
      errs++;
      $display("FAIL flush_cycle got=%b want=0001 (wr_ready,w_en,r_addr_en,rd_valid)",
               {wr_ready, ram_w_en, ram_r_addr_en, rd_valid});
    end
    vecs++;
    if (rd_data !== pat(300)) begin
      errs++;
      $display("FAIL flush_pop got=%h want=%h", rd_data, pat(300));
    end
    cyc();
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wr_valid = (c == 0);
      wr_data  = dn;
      #3;
      if (c == 0) begin
        vecs++;
        if ({rd_valid, level, wr_ready, ram_w_en, ram_w_addr} !== 7'b0_000_1_1_00) begin
          errs++;
          $display("FAIL flush_after rd_valid=%b level=%0d wr_ready=%b w_en=%b w_addr=%0d want 0 0 1 1 0",
                   rd_valid, level, wr_ready, ram_w_en, ram_w_addr);
        end
      end
      vecs++;
      if ({rd_valid, ram_r_addr_en} !== exp_tab[c] || (c == 1 && ram_r_addr !== 2'd0)) begin
        errs++;
        $display("FAIL flush_readback c=%0d got=%b r_addr=%0d want=%b r_addr=0",
                 c, {rd_valid, ram_r_addr_en}, ram_r_addr, exp_tab[c]);
      end
      if (c == 4) begin
        vecs++;
        if (rd_data !== dn) begin
          errs++;
          $display("FAIL flush_data got=%h want=%h", rd_data, dn);
        end
      end
      cyc();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_q.delete();
    rd_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      wr_valid = 1'b1;
      wr_data  = pat(500 + c);
      cyc();
    end
    wr_data = pat(507);
    #3;
    vecs++;
    if ({rd_valid, ram_w_en, ram_r_addr_en} !== 3'b111) begin
      errs++;
      $display("FAIL areset_pre got=%b want=111", {rd_valid, ram_w_en, ram_r_addr_en});
    end
    RESETN = 1'b0;
    #1;
    vecs++;
    if ({rd_valid, ram_w_en, ram_r_addr_en, wr_ready, ram_blk_en} !== 5'b0 || level !== 3'd0) begin
      errs++;
      $display("FAIL areset_now got=%b level=%0d want=00000 level=0",
               {rd_valid, ram_w_en, ram_r_addr_en, wr_ready, ram_blk_en}, level);
    end
    cyc();
    RESETN   = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    cyc();
    #3;
    vecs++;
    if ({level, ram_w_addr, ram_r_addr, rd_valid, ram_blk_en} !== 9'b000_00_00_0_1) begin
      errs++;
      $display("FAIL areset_after level=%0d w_addr=%0d r_addr=%0d rd_valid=%b blk_en=%b want 0 0 0 0 1",
               level, ram_w_addr, ram_r_addr, rd_valid, ram_blk_en);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_write({11{8'hA5}}, 2'd0, "single");
    test_fill();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_single_write(pat(4242), 2'd0, "post_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
